// File: rtl/countdown_pkg.sv
// Shared types and constants for the countdown sequencer and its glyph ROM.
package countdown_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_GO    = 2'd2
    } state_t;

    localparam int         GLYPH_W  = 16;
    localparam logic [3:0] GLYPH_GO = 4'hA;

    typedef logic [GLYPH_W-1:0] glyph_row_t;

    // Seven-segment map, bit order {a,b,c,d,e,f,g}; codes above 9 are blank.
    function automatic logic [6:0] seg_map(input logic [3:0] code);
        logic [6:0] seg;
        case (code)
            4'd0:    seg = 7'b1111110;
            4'd1:    seg = 7'b0110000;
            4'd2:    seg = 7'b1101101;
            4'd3:    seg = 7'b1111001;
            4'd4:    seg = 7'b0110011;
            4'd5:    seg = 7'b1011011;
            4'd6:    seg = 7'b1011111;
            4'd7:    seg = 7'b1110000;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1111011;
            default: seg = 7'b0000000;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/countdown_glyph_rom.sv
// Combinational 16x16 glyph table: digits 0..9 drawn as segment strokes, plus a GO bitmap.
module countdown_glyph_rom
    import countdown_pkg::*;
(
    input  logic [3:0]                i_code,
    output glyph_row_t [GLYPH_W-1:0]  o_glyph
);

    localparam glyph_row_t BAR   = 16'h0FF0;
    localparam glyph_row_t LEFT  = 16'h0C00;
    localparam glyph_row_t RIGHT = 16'h0030;

    localparam glyph_row_t GO_ROWS [GLYPH_W] = '{
        16'h0000, 16'h7E7E, 16'h4042, 16'h4042, 16'h4042, 16'h4042, 16'h4042, 16'h4E42,
        16'h4242, 16'h4242, 16'h4242, 16'h4242, 16'h4242, 16'h4242, 16'h7E7E, 16'h0000
    };

    logic [6:0] w_seg;

    // Upper half carries a/f/b, rows 7-8 the g bar, lower half e/c/d.
    always_comb begin
        w_seg = seg_map(i_code);
        for (int r = 0; r < GLYPH_W; r++) begin
            if (i_code == GLYPH_GO) begin
                o_glyph[r] = GO_ROWS[r];
            end else begin
                o_glyph[r] = (((r == 1) || (r == 2))   && w_seg[6] ? BAR   : 16'h0000)
                           | ((r >= 1) && (r <= 7)     && w_seg[5] ? RIGHT : 16'h0000)
                           | ((r >= 8) && (r <= 14)    && w_seg[4] ? RIGHT : 16'h0000)
                           | (((r == 13) || (r == 14)) && w_seg[3] ? BAR   : 16'h0000)
                           | ((r >= 8) && (r <= 14)    && w_seg[2] ? LEFT  : 16'h0000)
                           | ((r >= 1) && (r <= 7)     && w_seg[1] ? LEFT  : 16'h0000)
                           | (((r == 7) || (r == 8))   && w_seg[0] ? BAR   : 16'h0000);
            end
        end
    end

endmodule

// File: rtl/countdown_sequencer.sv
// Countdown display sequencer: IDLE -> COUNT (START_COUNT..1) -> GO -> IDLE,
// rendering the current glyph centred in a ROWS x COLS frame.
module countdown_sequencer
    import countdown_pkg::*;
#(
    parameter int ROWS           = 16,
    parameter int COLS           = 16,
    parameter int START_COUNT    = 3,
    parameter int TICKS_PER_STEP = 60,
    parameter int GO_TICKS       = 60,
    parameter int BLINK_TICKS    = 0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       tick,
    input  logic                       start,
    input  logic                       abort,
    output logic [ROWS-1:0][COLS-1:0]  pix,
    output logic [3:0]                 count_val,
    output logic                       busy,
    output logic                       go,
    output logic                       done
);

    localparam int TMAX    = (TICKS_PER_STEP > GO_TICKS) ? TICKS_PER_STEP : GO_TICKS;
    localparam int CNT_W   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int ROW_OFF = (ROWS - GLYPH_W) / 2;
    localparam int COL_OFF = (COLS - GLYPH_W) / 2;
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(TICKS_PER_STEP - 1);
    localparam logic [CNT_W-1:0] GO_LAST   = CNT_W'(GO_TICKS - 1);

    state_t                    r_state, w_state;
    logic [3:0]                r_count, w_count;
    logic [CNT_W-1:0]          r_tick_cnt, w_tick_cnt;
    logic                      r_done, w_done;
    logic                      r_busy, r_go;
    logic [3:0]                w_code;
    logic                      w_blank, w_show;
    glyph_row_t [GLYPH_W-1:0]  w_glyph;
    logic [ROWS-1:0][COLS-1:0] w_pix;

    // Next-state logic: abort wins over everything, start is only heard in IDLE.
    always_comb begin
        w_state    = r_state;
        w_count    = r_count;
        w_tick_cnt = r_tick_cnt;
        w_done     = 1'b0;
        if (abort) begin
            w_state    = ST_IDLE;
            w_count    = 4'd0;
            w_tick_cnt = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start && (START_COUNT == 0)) begin
                        w_state    = ST_GO;
                        w_tick_cnt = '0;
                    end else if (start) begin
                        w_state    = ST_COUNT;
                        w_count    = 4'(START_COUNT);
                        w_tick_cnt = '0;
                    end else begin
                        w_state = ST_IDLE;
                    end
                end
                ST_COUNT: begin
                    if (tick && (r_tick_cnt == STEP_LAST)) begin
                        w_tick_cnt = '0;
                        if (r_count == 4'd1) begin
                            w_state = ST_GO;
                            w_count = 4'd0;
                        end else begin
                            w_count = r_count - 4'd1;
                        end
                    end else if (tick) begin
                        w_tick_cnt = r_tick_cnt + CNT_W'(1);
                    end else begin
                        w_tick_cnt = r_tick_cnt;
                    end
                end
                ST_GO: begin
                    if (tick && (r_tick_cnt == GO_LAST)) begin
                        w_state    = ST_IDLE;
                        w_tick_cnt = '0;
                        w_done     = 1'b1;
                    end else if (tick) begin
                        w_tick_cnt = r_tick_cnt + CNT_W'(1);
                    end else begin
                        w_tick_cnt = r_tick_cnt;
                    end
                end
                default: begin
                    w_state    = ST_IDLE;
                    w_count    = 4'd0;
                    w_tick_cnt = '0;
                end
            endcase
        end
    end

    // State, counters and status flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_count    <= 4'd0;
            r_tick_cnt <= '0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_go       <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_count    <= w_count;
            r_tick_cnt <= w_tick_cnt;
            r_done     <= w_done;
            r_busy     <= (w_state != ST_IDLE);
            r_go       <= (w_state == ST_GO);
        end
    end

    assign count_val = r_count;
    assign busy      = r_busy;
    assign go        = r_go;
    assign done      = r_done;

    // Blink blanks the tail of each digit step; the GO glyph never blinks.
    assign w_blank = (BLINK_TICKS > 0) && (int'(r_tick_cnt) >= (TICKS_PER_STEP - BLINK_TICKS));
    assign w_show  = (r_state == ST_GO) || ((r_state == ST_COUNT) && !w_blank);
    assign w_code  = (r_state == ST_GO) ? GLYPH_GO : r_count;

    countdown_glyph_rom u_glyph (
        .i_code  (w_code),
        .o_glyph (w_glyph)
    );

    // Place the glyph centred; leftmost column is the MSB of each frame row.
    always_comb begin
        w_pix = '0;
        if (w_show) begin
            for (int r = 0; r < GLYPH_W; r++) begin
                w_pix[ROW_OFF + r][COLS-1-COL_OFF -: GLYPH_W] = w_glyph[r];
            end
        end else begin
            w_pix = '0;
        end
    end

    assign pix = w_pix;

endmodule

// File: tb/tb_countdown_sequencer.sv
// Scoreboard bench: three instances (plain 16x16, 32x24 with blink, START_COUNT=0) share stimulus.
module tb_countdown_sequencer;

    logic clk = 1'b0;
    logic reset_n, tick, start, abort;
    logic [15:0][15:0] pix_a, pix_c;
    logic [31:0][23:0] pix_b;
    logic [3:0] cv_a, cv_b, cv_c;
    logic busy_a, busy_b, busy_c, go_a, go_b, go_c, done_a, done_b, done_c;

    int n_vec = 0;
    int n_err = 0;

    localparam int GO = 10;

    localparam logic [15:0] D1 [16] = '{16'h0000, 16'h0030, 16'h0030, 16'h0030, 16'h0030, 16'h0030,
        16'h0030, 16'h0030, 16'h0030, 16'h0030, 16'h0030, 16'h0030, 16'h0030, 16'h0030, 16'h0030, 16'h0000};
    localparam logic [15:0] D2 [16] = '{16'h0000, 16'h0FF0, 16'h0FF0, 16'h0030, 16'h0030, 16'h0030,
        16'h0030, 16'h0FF0, 16'h0FF0, 16'h0C00, 16'h0C00, 16'h0C00, 16'h0C00, 16'h0FF0, 16'h0FF0, 16'h0000};
    localparam logic [15:0] D3 [16] = '{16'h0000, 16'h0FF0, 16'h0FF0, 16'h0030, 16'h0030, 16'h0030,
        16'h0030, 16'h0FF0, 16'h0FF0, 16'h0030, 16'h0030, 16'h0030, 16'h0030, 16'h0FF0, 16'h0FF0, 16'h0000};
    localparam logic [15:0] DG [16] = '{16'h0000, 16'h7E7E, 16'h4042, 16'h4042, 16'h4042, 16'h4042,
        16'h4042, 16'h4E42, 16'h4242, 16'h4242, 16'h4242, 16'h4242, 16'h4242, 16'h4242, 16'h7E7E, 16'h0000};

    typedef struct {
        logic [6:0]   ctl;     // {count_val, busy, go, done} of A and B
        logic [6:0]   c_ctl;   // {count_val, busy, go, done} of C
        logic [255:0] a_pix;
        logic [767:0] b_pix;
        logic [255:0] c_pix;
    } exp_t;

    exp_t sb[$];

    countdown_sequencer #(.ROWS(16), .COLS(16), .START_COUNT(3), .TICKS_PER_STEP(4), .GO_TICKS(2), .BLINK_TICKS(0))
    dut_a (.clk(clk), .reset_n(reset_n), .tick(tick), .start(start), .abort(abort),
           .pix(pix_a), .count_val(cv_a), .busy(busy_a), .go(go_a), .done(done_a));

    countdown_sequencer #(.ROWS(32), .COLS(24), .START_COUNT(3), .TICKS_PER_STEP(4), .GO_TICKS(2), .BLINK_TICKS(1))
    dut_b (.clk(clk), .reset_n(reset_n), .tick(tick), .start(start), .abort(abort),
           .pix(pix_b), .count_val(cv_b), .busy(busy_b), .go(go_b), .done(done_b));

    countdown_sequencer #(.ROWS(16), .COLS(16), .START_COUNT(0), .TICKS_PER_STEP(4), .GO_TICKS(2), .BLINK_TICKS(0))
    dut_c (.clk(clk), .reset_n(reset_n), .tick(tick), .start(start), .abort(abort),
           .pix(pix_c), .count_val(cv_c), .busy(busy_c), .go(go_c), .done(done_c));

    always #5 clk = ~clk;

    function automatic logic [15:0] glyph_row(input int code, input int r);
        case (code)
            1:       return D1[r];
            2:       return D2[r];
            3:       return D3[r];
            GO:      return DG[r];
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [255:0] exp_pix16(input int code);
        logic [255:0] v = '0;
        if (code >= 0) for (int r = 0; r < 16; r++) v[r*16 +: 16] = glyph_row(code, r);
        return v;
    endfunction

    // Rows 8..23, columns 4..19 of a 32x24 frame.
    function automatic logic [767:0] exp_pix_big(input int code);
        logic [767:0] v = '0;
        if (code >= 0) for (int r = 0; r < 16; r++) v[(8 + r)*24 + 4 +: 16] = glyph_row(code, r);
        return v;
    endfunction

    function automatic exp_t make_exp(input int cv, input bit busy, input bit g, input bit d,
                                      input bit blank_b, input bit c_go, input bit c_done);
        exp_t e;
        int   code;
        code    = g ? GO : (busy ? cv : -1);
        e.ctl   = {4'(cv), busy, g, d};
        e.c_ctl = {4'd0, c_go, c_go, c_done};
        e.a_pix = exp_pix16(code);
        e.b_pix = exp_pix_big(blank_b ? -1 : code);
        e.c_pix = exp_pix16(c_go ? GO : -1);
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; tick = 1'b0; start = 1'b0; abort = 1'b0;
        repeat (2) step();
        n_vec += 3;
        if ({cv_a, busy_a, go_a, done_a, pix_a} !== 263'd0) begin
            n_err++; $display("FAIL reset_a got %h want 0", {cv_a, busy_a, go_a, done_a, pix_a});
        end
        if ({cv_b, busy_b, go_b, done_b, pix_b} !== 775'd0) begin
            n_err++; $display("FAIL reset_b got %h want 0", {cv_b, busy_b, go_b, done_b});
        end
        if ({cv_c, busy_c, go_c, done_c, pix_c} !== 263'd0) begin
            n_err++; $display("FAIL reset_c got %h want 0", {cv_c, busy_c, go_c, done_c});
        end
        reset_n = 1'b1;
    endtask

    // Tick tied high; a second start at sample 6 must be ignored by A/B but restarts idle C.
    task automatic test_full_sequence();
        exp_t e;
        for (int s = 1; s <= 16; s++) begin
            int cv;
            cv = (s <= 4) ? 3 : (s <= 8) ? 2 : (s <= 12) ? 1 : 0;
            sb.push_back(make_exp(cv, s <= 14, (s == 13) || (s == 14), s == 15,
                                  (s <= 12) && (s % 4 == 0),
                                  (s == 1) || (s == 2) || (s == 6) || (s == 7), (s == 3) || (s == 8)));
            start = (s == 1) || (s == 6); tick = 1'b1; abort = 1'b0;
            step();
            start = 1'b0;
            e = sb.pop_front();
            n_vec += 4;
            if ({cv_a, busy_a, go_a, done_a} !== e.ctl) begin
                n_err++; $display("FAIL full_seq ctl_a s=%0d got %h want %h", s, {cv_a, busy_a, go_a, done_a}, e.ctl);
            end
            if (pix_a !== e.a_pix) begin
                n_err++; $display("FAIL full_seq pix_a s=%0d got %h want %h", s, pix_a, e.a_pix);
            end
            if (pix_b !== e.b_pix || {cv_b, busy_b, go_b, done_b} !== e.ctl) begin
                n_err++; $display("FAIL full_seq dut_b s=%0d got %h want %h", s, pix_b, e.b_pix);
            end
            if ({cv_c, busy_c, go_c, done_c, pix_c} !== {e.c_ctl, e.c_pix}) begin
                n_err++; $display("FAIL full_seq dut_c s=%0d got %h want %h", s, {cv_c, busy_c, go_c, done_c}, e.c_ctl);
            end
        end
    endtask

    // Abort (with a simultaneous start) on the second cycle of digit 2.
    task automatic test_abort();
        exp_t e;
        for (int s = 1; s <= 8; s++) begin
            int cv;
            cv = (s <= 4) ? 3 : (s <= 6) ? 2 : 0;
            sb.push_back(make_exp(cv, s <= 6, 1'b0, 1'b0, s == 4, (s == 1) || (s == 2), s == 3));
            start = (s == 1) || (s == 7); abort = (s == 7); tick = 1'b1;
            step();
            start = 1'b0; abort = 1'b0;
            e = sb.pop_front();
            n_vec += 4;
            if ({cv_a, busy_a, go_a, done_a} !== e.ctl) begin
                n_err++; $display("FAIL abort ctl_a s=%0d got %h want %h", s, {cv_a, busy_a, go_a, done_a}, e.ctl);
            end
            if (pix_a !== e.a_pix) begin
                n_err++; $display("FAIL abort pix_a s=%0d got %h want %h", s, pix_a, e.a_pix);
            end
            if (pix_b !== e.b_pix || {cv_b, busy_b, go_b, done_b} !== e.ctl) begin
                n_err++; $display("FAIL abort dut_b s=%0d got %h want %h", s, pix_b, e.b_pix);
            end
            if ({cv_c, busy_c, go_c, done_c, pix_c} !== {e.c_ctl, e.c_pix}) begin
                n_err++; $display("FAIL abort dut_c s=%0d got %h want %h", s, {cv_c, busy_c, go_c, done_c}, e.c_ctl);
            end
        end
    endtask

    // Counters must hold while tick is low; the tick on the start edge is not counted.
    task automatic test_tick_hold();
        exp_t e;
        for (int s = 1; s <= 9; s++) begin
            sb.push_back(make_exp((s <= 8) ? 3 : 0, s <= 8, 1'b0, 1'b0, s == 8, s <= 6, s == 7));
            start = (s == 1); tick = (s == 1) || (s >= 6); abort = (s == 9);
            step();
            start = 1'b0; abort = 1'b0;
            e = sb.pop_front();
            n_vec += 4;
            if ({cv_a, busy_a, go_a, done_a} !== e.ctl) begin
                n_err++; $display("FAIL tick_hold ctl_a s=%0d got %h want %h", s, {cv_a, busy_a, go_a, done_a}, e.ctl);
            end
            if (pix_a !== e.a_pix) begin
                n_err++; $display("FAIL tick_hold pix_a s=%0d got %h want %h", s, pix_a, e.a_pix);
            end
            if (pix_b !== e.b_pix || {cv_b, busy_b, go_b, done_b} !== e.ctl) begin
                n_err++; $display("FAIL tick_hold dut_b s=%0d got %h want %h", s, pix_b, e.b_pix);
            end
            if ({cv_c, busy_c, go_c, done_c, pix_c} !== {e.c_ctl, e.c_pix}) begin
                n_err++; $display("FAIL tick_hold dut_c s=%0d got %h want %h", s, {cv_c, busy_c, go_c, done_c}, e.c_ctl);
            end
        end
    endtask

    // Asynchronous reset in the middle of GO: outputs clear without a clock edge, no done follows.
    task automatic test_reset_mid_go();
        start = 1'b1; tick = 1'b1; abort = 1'b0;
        step();
        start = 1'b0;
        repeat (12) step();
        n_vec++;
        if ({busy_a, go_a, pix_a} !== {1'b1, 1'b1, exp_pix16(GO)}) begin
            n_err++; $display("FAIL rst_go pre_go got %b%b want 11", busy_a, go_a);
        end
        #2 reset_n = 1'b0;
        #1;
        n_vec += 2;
        if ({cv_a, busy_a, go_a, done_a, pix_a} !== 263'd0) begin
            n_err++; $display("FAIL rst_go async_a got %h want 0", {cv_a, busy_a, go_a, done_a});
        end
        if ({cv_b, busy_b, go_b, done_b, pix_b} !== 775'd0) begin
            n_err++; $display("FAIL rst_go async_b got %h want 0", {cv_b, busy_b, go_b, done_b});
        end
        step();
        #2 reset_n = 1'b1;
        for (int s = 0; s < 3; s++) begin
            step();
            n_vec++;
            if ({cv_a, busy_a, go_a, done_a, done_b, pix_a} !== 264'd0) begin
                n_err++; $display("FAIL rst_go after s=%0d got %h want 0", s, {cv_a, busy_a, go_a, done_a, done_b});
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_sequence();
        test_abort();
        test_tick_hold();
        test_reset_mid_go();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
